// File: rtl/bcd_to_bin_conv_pkg.sv
// rtl/bcd_to_bin_conv_pkg.sv - shared BCD constants, FSM encodings and width helper
// Reused by the BCD arithmetic blocks that feed or sit beside the converter.
package bcd_to_bin_conv_pkg;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Smallest binary width able to hold 10**ndig - 1.
  function automatic int bcd_min_bw(input int ndig);
    longint p;
    p = 1;
    for (int i = 0; i < ndig; i++) begin
      p = p * 10;
    end
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_to_bin_conv_if.sv
// rtl/bcd_to_bin_conv_if.sv - valid/ready input and output channels of the converter
// The converter connects through the slave modport; the producer/consumer side uses master.
interface bcd_to_bin_conv_if
  import bcd_to_bin_conv_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int BW   = 10
);

  logic                        in_valid;
  logic                        in_ready;
  logic [BCD_DIGIT_W*NDIG-1:0] bcd_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [BW-1:0]               bin_out;
  logic                        err;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err
  );

endinterface

// File: rtl/bcd_to_bin_conv_digit_mac.sv
// rtl/bcd_to_bin_conv_digit_mac.sv - combinational acc*10+digit step with bad-digit flag
// acc*10 is formed as (acc<<3)+(acc<<1) so no multiplier is inferred.
module bcd_digit_mac
  import bcd_to_bin_conv_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic [AW-1:0]          acc,
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [AW-1:0]          acc_next,
  output logic                   bad_digit
);

  always_comb begin
    acc_next  = (acc << 3) + (acc << 1) + AW'(d);
    bad_digit = (d > BCD_DIGIT_W'(BCD_MAX_DIGIT));
  end

endmodule

// File: rtl/bcd_to_bin_conv.sv
// rtl/bcd_to_bin_conv.sv - digit-serial packed BCD to binary converter, MS digit first
// One digit per clock; a word is accepted only in IDLE and its result held in DONE.
module bcd_to_bin_conv
  import bcd_to_bin_conv_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_to_bin_conv_if.slave      bus
);

  localparam int SW = BCD_DIGIT_W * NDIG;
  localparam int AW = BW + BCD_DIGIT_W;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (NDIG < 1 || BW < bcd_min_bw(NDIG)) begin : g_bad_params
      $error("bcd_to_bin_conv: BW too small for NDIG digits");
    end
  endgenerate

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [SW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_acc_q, err_acc_d;
  logic [BW-1:0] bin_q, bin_d;
  logic          err_q, err_d;

  logic [AW-1:0] mac_out;
  logic          bad_digit;
  logic          err_now;

  bcd_digit_mac #(
    .AW (AW)
  ) u_mac (
    .acc       (acc_q),
    .d         (sr_q[SW-1 -: BCD_DIGIT_W]),
    .acc_next  (mac_out),
    .bad_digit (bad_digit)
  );

  // Error state including the digit being consumed this cycle.
  assign err_now = err_acc_q | bad_digit;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    err_acc_d = err_acc_q;
    bin_d     = bin_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sr_d      = bus.bcd_in;
          acc_d     = '0;
          err_acc_d = 1'b0;
          cnt_d     = CW'(NDIG - 1);
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        acc_d     = mac_out;
        sr_d      = sr_q << BCD_DIGIT_W;
        err_acc_d = err_now;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          bin_d   = err_now ? '0 : mac_out[BW-1:0];
          err_d   = err_now;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      bin_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      err_acc_q <= err_acc_d;
      bin_q     <= bin_d;
      err_q     <= err_d;
    end
  end

  // Handshake flags decode straight from state so reset clears them immediately.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.bin_out   = bin_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin_conv.sv
// tb/tb_bcd_to_bin_conv.sv - directed self-checking bench for bcd_to_bin_conv
// Inputs change and outputs are sampled on the falling edge unless a test needs finer timing.
module tb_bcd_to_bin_conv;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  bcd_to_bin_conv_if #(.NDIG(3), .BW(10)) bus ();

  bcd_to_bin_conv #(.NDIG(3), .BW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] bcd3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Convert one word with out_ready held high; returns the result seen while out_valid=1.
  task automatic run_word(input logic [11:0] w, output logic [9:0] b, output logic e,
                          output bit to);
    int n;
    to = 1'b0;
    b  = '0;
    e  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      to = 1'b1;
      return;
    end
    bus.in_valid = 1'b1;
    bus.bcd_in   = w;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.bcd_in   = 12'hFFF;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      to = 1'b1;
      return;
    end
    b = bus.bin_out;
    e = bus.err;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [9:0] b;
    logic       e;
    bit         to;
    bit         seen;
    @(negedge clk);
    total++;
    if ({bus.in_ready, bus.out_valid, bus.err} !== 3'b100 || bus.bin_out !== 10'd0) begin
      bad++;
      $display("FAIL reset_state got rdy/vld/err=%b bin=%0d want 100 bin=0",
               {bus.in_ready, bus.out_valid, bus.err}, bus.bin_out);
    end
    rst = 1'b0;
    run_word(12'h045, b, e, to);
    total++;
    if (to || b !== 10'd45 || e !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset_045 got bin=%0d err=%b to=%0d want bin=45 err=0", b, e, to);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bcd_in   = 12'h123;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.err} !== 3'b100 || bus.bin_out !== 10'd0) begin
      bad++;
      $display("FAIL async_reset got rdy/vld/err=%b bin=%0d want 100 bin=0",
               {bus.in_ready, bus.out_valid, bus.err}, bus.bin_out);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_drops_word got out_valid seen=%0d want 0", seen);
    end
    run_word(12'h045, b, e, to);
    total++;
    if (to || b !== 10'd45 || e !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_045 got bin=%0d err=%b to=%0d want bin=45 err=0", b, e, to);
    end
  endtask

  task automatic test_latency();
    int lat;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bcd_in   = 12'h199;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
    total++;
    if (lat !== 3 || bus.bin_out !== 10'd199 || bus.err !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL latency_199 got lat=%0d bin=%0d err=%b rdy=%b want lat=3 bin=199 err=0 rdy=0",
               lat, bus.bin_out, bus.err, bus.in_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_handshake got vld=%b rdy=%b want vld=0 rdy=1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_boundaries();
    logic [11:0] words[4];
    int          exp_v[4];
    logic [9:0]  b;
    logic        e;
    bit          to;
    words = '{12'h000, 12'h999, 12'h009, 12'h900};
    exp_v = '{0, 999, 9, 900};
    for (int i = 0; i < 4; i++) begin
      run_word(words[i], b, e, to);
      total++;
      if (to || b !== 10'(exp_v[i]) || e !== 1'b0) begin
        bad++;
        $display("FAIL boundary_%03h got bin=%0d err=%b to=%0d want bin=%0d err=0",
                 words[i], b, e, to, exp_v[i]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [11:0] words[4];
    int          exp_v[4];
    logic        exp_e[4];
    logic [9:0]  b;
    logic        e;
    bit          to;
    words = '{12'h1A3, 12'h021, 12'hF00, 12'h99B};
    exp_v = '{0, 21, 0, 0};
    exp_e = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_word(words[i], b, e, to);
      total++;
      if (to || b !== 10'(exp_v[i]) || e !== exp_e[i]) begin
        bad++;
        $display("FAIL invalid_%03h got bin=%0d err=%b to=%0d want bin=%0d err=%b",
                 words[i], b, e, to, exp_v[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit held_ok;
    bit seen;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bcd_in   = 12'h087;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.bin_out !== 10'd87) begin
      bad++;
      $display("FAIL bp_result got vld=%b bin=%0d want vld=1 bin=87", bus.out_valid, bus.bin_out);
    end
    held_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.bin_out !== 10'd87 ||
          bus.err !== 1'b0) held_ok = 1'b0;
      if (i == 2) begin
        bus.in_valid = 1'b1;
        bus.bcd_in   = 12'h555;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    total++;
    if (held_ok !== 1'b1) begin
      bad++;
      $display("FAIL bp_hold got held_ok=%0d want 1 (last vld=%b rdy=%b bin=%0d)",
               held_ok, bus.out_valid, bus.in_ready, bus.bin_out);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.bin_out !== 10'd87) begin
      bad++;
      $display("FAIL bp_release got vld=%b rdy=%b bin=%0d want vld=0 rdy=1 bin=87",
               bus.out_valid, bus.in_ready, bus.bin_out);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid || !bus.in_ready) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL bp_ignored_555 got activity=%0d want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    fork
      begin : driver
        int n;
        int last;
        last = -1;
        @(negedge clk);
        for (int v = 0; v < 200; v++) begin
          bus.in_valid = 1'b1;
          bus.bcd_in   = bcd3(v);
          n = 0;
          while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
          end
          if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL sweep_accept_timeout got word=%0d not accepted want accepted", v);
            break;
          end
          if (last >= 0) begin
            total++;
            if (cyc - last < 5) begin
              bad++;
              $display("FAIL sweep_throughput got %0d cycles/word want >=5 at word %0d",
                       cyc - last, v);
            end
          end
          last = cyc;
          @(negedge clk);
        end
        bus.in_valid = 1'b0;
      end
      begin : monitor
        int got;
        int n;
        got = 0;
        n   = 0;
        while (got < 200 && n < 5000) begin
          @(negedge clk);
          n++;
          bus.out_ready = 1'($urandom_range(0, 1));
          if (bus.out_valid && bus.out_ready) begin
            total++;
            if (bus.bin_out !== 10'(got) || bus.err !== 1'b0) begin
              bad++;
              $display("FAIL sweep_value got bin=%0d err=%b want bin=%0d err=0",
                       bus.bin_out, bus.err, got);
            end
            got++;
          end
        end
        total++;
        if (got !== 200) begin
          bad++;
          $display("FAIL sweep_count got %0d results want 200", got);
        end
        bus.out_ready = 1'b1;
      end
    join
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_latency();
    test_boundaries();
    test_invalid();
    test_backpressure();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
